// File: rtl/ex_bypass_network.sv
// ex_bypass_network
//   EX-stage operand forwarding network. Keeps a DEPTH-entry history of
//   in-flight producer results (entry 0 youngest) and forwards the youngest
//   matching result to rs1/rs2. Handles late-arriving load data: a fill is
//   forwarded on its arrival cycle and written into history; a consumer that
//   needs a still-pending value raises hazard_stall.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   stall_in            pipeline freeze: history holds, push ignored
//   rs1_*/rs2_*         consumer source addresses, use flags, regfile values
//   pc, imm, use_pc,
//   use_imm             ALU operand muxing
//   wr_en/addr/data/
//   wr_ready            producer leaving EX (wr_ready=0 for loads)
//   fill_valid/data     late load data
//   rs1_br, rs2_br      forwarded source values
//   rs1_in, rs2_in      ALU operands
//   hazard_stall        consumer needs data that is not ready yet
//   stall_count         saturating count of hazard_stall cycles
//   proto_err           sticky: a not-ready entry retired without a fill
module ex_bypass_network #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned AW    = 5,
    parameter int unsigned CW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic [XLEN-1:0] rs1_rf,
    input  logic [XLEN-1:0] rs2_rf,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            use_pc,
    input  logic            use_imm,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            wr_ready,
    input  logic            fill_valid,
    input  logic [XLEN-1:0] fill_data,
    output logic [XLEN-1:0] rs1_br,
    output logic [XLEN-1:0] rs2_br,
    output logic [XLEN-1:0] rs1_in,
    output logic [XLEN-1:0] rs2_in,
    output logic            hazard_stall,
    output logic [CW-1:0]   stall_count,
    output logic            proto_err
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] ready_q;
    logic [AW-1:0]    rd_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];

    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] tgt_oh;
    logic [DEPTH-1:0] fill_hit;
    logic             retire_err;
    logic [XLEN:0]    lk1;
    logic [XLEN:0]    lk2;

    // Fill target: oldest valid entry still waiting for its data. Later
    // (older) hits overwrite earlier ones so the result is one-hot.
    always_comb begin
        pend   = valid_q & ~ready_q;
        tgt_oh = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (pend[i]) begin
                tgt_oh    = '0;
                tgt_oh[i] = 1'b1;
            end
        end
        fill_hit   = fill_valid ? tgt_oh : '0;
        retire_err = !stall_in && pend[DEPTH-1] && !fill_hit[DEPTH-1];
    end

    // Returns {hazard, value} for one source; youngest match wins.
    function automatic logic [XLEN:0] lookup(
        input logic [AW-1:0]   addr,
        input logic            used,
        input logic [XLEN-1:0] rf
    );
        logic          found;
        logic [XLEN:0] res;
        found = 1'b0;
        res   = {1'b0, rf};
        if (addr == '0) begin
            res = '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!found && valid_q[i] && (rd_q[i] == addr)) begin
                    found = 1'b1;
                    if (ready_q[i])
                        res = {1'b0, data_q[i]};
                    else if (fill_hit[i])
                        res = {1'b0, fill_data};
                    else
                        res = {used, data_q[i]};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        lk1 = lookup(rs1_addr, rs1_used, rs1_rf);
        lk2 = lookup(rs2_addr, rs2_used, rs2_rf);
        // History is only cleared at the edge, so mask it while in reset.
        if (!rst) begin
            rs1_br       = rs1_rf;
            rs2_br       = rs2_rf;
            hazard_stall = 1'b0;
        end else begin
            rs1_br       = lk1[XLEN-1:0];
            rs2_br       = lk2[XLEN-1:0];
            hazard_stall = lk1[XLEN] | lk2[XLEN];
        end
        rs1_in = use_pc  ? pc  : rs1_br;
        rs2_in = use_imm ? imm : rs2_br;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q     <= '0;
            ready_q     <= '0;
            stall_count <= '0;
            proto_err   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (!stall_in) begin
                // Shift, merging the fill into the entry as it moves down;
                // a fill aimed at the oldest entry leaves with it.
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    rd_q[i]    <= rd_q[i-1];
                    data_q[i]  <= fill_hit[i-1] ? fill_data : data_q[i-1];
                    ready_q[i] <= ready_q[i-1] | fill_hit[i-1];
                end
                valid_q[0] <= wr_en && (wr_addr != '0);
                rd_q[0]    <= wr_addr;
                data_q[0]  <= wr_data;
                ready_q[0] <= wr_ready;
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (fill_hit[i]) begin
                        data_q[i]  <= fill_data;
                        ready_q[i] <= 1'b1;
                    end
                end
            end
            if (retire_err)
                proto_err <= 1'b1;
            if (hazard_stall && (stall_count != '1))
                stall_count <= stall_count + CW'(1);
        end
    end

endmodule

// File: doc/ex_bypass_network.md
Name: ex_bypass_network

Overview:
- Parametrised successor to the EX-stage operand forwarding mux.
- Holds a DEPTH-entry history of in-flight producer results, one entry per pipeline stage past EX.
- Selects the youngest matching result for rs1/rs2, with zero-register handling.
- Handles loads whose data arrives late: forwards it on the arrival cycle, otherwise raises a load-use stall. Also produces the ALU operands (pc/imm muxing) and sticky stall/error statistics.

Parameters:
XLEN, 32, datapath width
DEPTH, 3, history entries (in-flight producer stages tracked), min 1
AW, 5, register address width
CW, 16, stall counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-low reset (0 = reset)
stall_in  in  1  pipeline freeze; history holds
rs1_addr  in  AW  consumer source 1
rs2_addr  in  AW  consumer source 2
rs1_used  in  1  consumer reads rs1
rs2_used  in  1  consumer reads rs2
rs1_rf  in  XLEN  regfile value rs1
rs2_rf  in  XLEN  regfile value rs2
pc  in  XLEN  consumer PC
imm  in  XLEN  consumer immediate
use_pc  in  1  ALU A = pc
use_imm  in  1  ALU B = imm
wr_en  in  1  producer leaving EX this cycle writes rd
wr_addr  in  AW  producer rd
wr_data  in  XLEN  producer result
wr_ready  in  1  wr_data valid now (0 for loads)
fill_valid  in  1  late load data arriving
fill_data  in  XLEN  late load data
rs1_br  out  XLEN  forwarded rs1 (branch compare)
rs2_br  out  XLEN  forwarded rs2 (branch compare, store data)
rs1_in  out  XLEN  ALU operand A
rs2_in  out  XLEN  ALU operand B
hazard_stall  out  1  consumer must stall (data not ready)
stall_count  out  CW  saturating count of hazard_stall cycles
proto_err  out  1  sticky: not-ready entry retired unfilled

Behaviour:
- Entry i = {valid, rd, data, ready}. Entry 0 is the youngest and entry DEPTH-1 the oldest.
- Reset (rst=0 at edge): all valid=0, ready=0, data=0, stall_count=0, proto_err=0.
- While in reset the outputs are combinational from the inputs with an empty history: rs*_br = rs*_rf, hazard_stall=0.
- Advance: when stall_in=0, entry i+1 <= entry i, and entry DEPTH-1 drops out.
  - Entry 0 <= {wr_en && wr_addr!=0, wr_addr, wr_data, wr_ready}.
  - When stall_in=1 there is no shift and the push is ignored.
- Fill target: the oldest valid entry with ready=0 (pre-edge state).
  - On fill_valid=1 the target gets data=fill_data, ready=1, written at its post-shift index.
  - fill_valid with no target is ignored.
- Retire error: if stall_in=0 and entry DEPTH-1 is valid with ready=0 and is not the fill target this cycle, set proto_err=1. It is sticky until reset.
- Lookup, combinational, for each source s (same rules for rs2):
  - If s_addr==0: value 0, no hazard.
  - Else find the youngest valid entry with rd==s_addr.
    - If ready: value = entry data.
    - Else if fill_valid and the entry is the fill target: value = fill_data (same-cycle bypass), no hazard.
    - Else: value = entry data (don't-care), hazard if s_used.
  - No match: value = s_rf.
- Outputs:
  - rs1_br/rs2_br are the lookup values.
  - rs1_in = use_pc ? pc : rs1_br; rs2_in = use_imm ? imm : rs2_br.
  - hazard_stall = OR of the rs1 and rs2 hazards.
- The unit does not self-insert bubbles. The pipeline drives wr_en=0 on the cycle after a hazard stall.
- stall_count increments on each edge where hazard_stall=1 and rst=1, saturating at 2^CW-1.
- All outputs except stall_count/proto_err are combinational (zero latency). History updates take effect the cycle after the edge.

Test Plan:
- Push wr_addr=5, data=0xAAAA, ready=1; next cycle rs1_addr=5 -> rs1_br=0xAAAA. After a second push wr_addr=5, data=0xBBBB -> rs1_br=0xBBBB (youngest wins).
- Load push wr_addr=7, ready=0; next cycle rs2_addr=7, rs2_used=1, no fill -> hazard_stall=1, stall_count 0->1. Next cycle fill_valid=1, fill_data=0x1234 -> rs2_br=0x1234, hazard_stall=0. A later cycle with no fill -> still 0x1234 from history.
- rs1_addr=0 with entry rd=0 attempted (wr_addr=0, wr_en=1) -> rs1_br=0, no entry valid. rs2_used=0 on a pending match -> hazard_stall=0.
- DEPTH=3: push x9=0x55 then 3 pushes to other regs -> x9 retired, rs1_br = rs1_rf = 0x66. An unfilled load shifted past entry 2 -> proto_err=1 until rst=0.
- stall_in=1 for 4 cycles with wr_en=1 -> history unchanged, forwarding unchanged. use_pc=1, use_imm=1, pc=0x100, imm=0x8 -> rs1_in=0x100, rs2_in=0x8 while rs1_br/rs2_br still forward.
- Hold hazard with CW=4 for 20 cycles -> stall_count saturates at 15. rst=0 mid-sequence -> count=0, history empty, proto_err=0 next cycle.
